// File: rtl/rs232_decimal_parser.sv
`default_nettype none
// ============================================================================
// Module   : rs232_decimal_parser
// Purpose  : Assembles an ASCII decimal line (digits followed by TERM_CHAR)
//            from the RS232 receiver into an unsigned WIDTH-bit operand.
//            A line that ends correctly gives a one-cycle number_valid pulse.
//            A bad byte gives a one-cycle parse_error pulse, and the rest of
//            that line is then dropped.
// Ports    : clk            - system clock
//            rst_n          - synchronous active-low reset
//            rx_data        - received byte, valid on a rising rx_data_ready
//            rx_data_ready  - receiver byte strobe (may be held as a level)
//            rx_error       - framing error flag for the current byte
//            number         - last valid operand, held between lines
//            number_valid   - 1-cycle pulse when number has just been updated
//            parse_error    - 1-cycle pulse when the current line is rejected
//            busy           - high while a line is partly received
// Revision : 1.0 - initial release
// ============================================================================
module rs232_decimal_parser #(
  parameter int         WIDTH      = 32,
  parameter int         MAX_DIGITS = 10,
  parameter logic [7:0] TERM_CHAR  = 8'h0D
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_data_ready,
  input  logic             rx_error,
  output logic [WIDTH-1:0] number,
  output logic             number_valid,
  output logic             parse_error,
  output logic             busy
);

  localparam int             CNT_W        = $clog2(MAX_DIGITS + 1);
  localparam logic [CNT_W-1:0] C_MAX_DIGITS = CNT_W'(MAX_DIGITS);
  localparam logic [7:0]     C_LF         = 8'h0A;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] number_q, number_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             prev_q;

  logic             accept;
  logic             is_digit;
  logic             is_term;
  logic             is_lf;
  logic [WIDTH+3:0] next_val;
  logic             overflow;

  // A held strobe level counts as a single byte: only its rising edge is taken.
  assign accept = rx_data_ready & ~prev_q;

  // A byte flagged with a framing error falls into none of the good classes,
  // so it is treated as BAD whatever its value.
  assign is_digit = ~rx_error & (rx_data >= 8'h30) & (rx_data <= 8'h39);
  assign is_term  = ~rx_error & (rx_data == TERM_CHAR);
  assign is_lf    = ~rx_error & (rx_data == C_LF);

  // Four extra bits hold acc*10+9 for any acc, so any carry into them means
  // the value no longer fits in WIDTH bits.
  assign next_val = ({4'b0000, acc_q} * (WIDTH + 4)'(10)) + (WIDTH + 4)'(rx_data[3:0]);
  assign overflow = |next_val[WIDTH+3:WIDTH];

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    number_d = number_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_digit) begin
            acc_d   = WIDTH'(rx_data[3:0]);
            cnt_d   = CNT_W'(1);
            state_d = ST_ACCUM;
          end else if (is_term || is_lf) begin
            // Blank line or stray LF: nothing to report.
            state_d = ST_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_DISCARD;
          end
        end
      end

      ST_ACCUM: begin
        if (accept) begin
          if (is_digit) begin
            if ((cnt_q == C_MAX_DIGITS) || overflow) begin
              err_d   = 1'b1;
              state_d = ST_DISCARD;
            end else begin
              acc_d = next_val[WIDTH-1:0];
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else if (is_term) begin
            number_d = acc_q;
            valid_d  = 1'b1;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = ST_IDLE;
          end else if (is_lf) begin
            state_d = ST_ACCUM;
          end else begin
            err_d   = 1'b1;
            state_d = ST_DISCARD;
          end
        end
      end

      ST_DISCARD: begin
        // Only the terminator ends a rejected line; everything else, even a
        // second bad byte, is swallowed silently.
        if (accept && is_term) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      number_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      prev_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      number_q <= number_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      prev_q   <= rx_data_ready;
    end
  end

  assign number       = number_q;
  assign number_valid = valid_q;
  assign parse_error  = err_q;
  assign busy         = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rs232_decimal_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_rs232_decimal_parser
// Purpose  : Directed-vector bench for rs232_decimal_parser. The driver pushes
//            each expected pulse (kind, value, arrival time) into a queue; an
//            independent monitor pops and compares whenever a pulse appears,
//            and checks the held number and the post-reset outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rs232_decimal_parser;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;
  localparam int EV_NONE  = 0;
  localparam int EV_VALID = 1;
  localparam int EV_ERR   = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_data_ready = 1'b0;
  logic        rx_error = 1'b0;
  logic [31:0] number;
  logic        number_valid;
  logic        parse_error;
  logic        busy;

  typedef struct {
    bit          is_err;
    logic [31:0] val;
    time         t;
  } ev_t;

  ev_t         sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_number = 32'd0;
  logic        rst_seen = 1'b0;
  logic        armed = 1'b0;
  bit          done = 1'b0;

  rs232_decimal_parser #(
    .WIDTH     (32),
    .MAX_DIGITS(10),
    .TERM_CHAR (8'h0D)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_data      (rx_data),
    .rx_data_ready(rx_data_ready),
    .rx_error     (rx_error),
    .number       (number),
    .number_valid (number_valid),
    .parse_error  (parse_error),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- driver
  task automatic send(input logic [7:0] b, input logic err, input int kind,
                      input logic [31:0] val);
    ev_t e;
    @(negedge clk);
    if (kind != EV_NONE) begin
      e.is_err = (kind == EV_ERR);
      e.val    = val;
      e.t      = $time + 10;   // taken at the next posedge, seen at the negedge after
      sb_q.push_back(e);
    end
    rx_data       = b;
    rx_error      = err;
    rx_data_ready = 1'b1;
    @(negedge clk);
    rx_data_ready = 1'b0;
    rx_error      = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i], 1'b0, EV_NONE, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // T1 basic
    send_str("1234");        send(CR, 1'b0, EV_VALID, 32'd1234);
    // T2 boundaries
    send_str("4294967295");  send(CR, 1'b0, EV_VALID, 32'hFFFF_FFFF);
    send_str("429496729");   send("6", 1'b0, EV_ERR, 32'hFFFF_FFFF);
    send(CR, 1'b0, EV_NONE, 32'd0);
    send_str("0000000000");  send(CR, 1'b0, EV_VALID, 32'd0);
    send_str("0000000000");  send("1", 1'b0, EV_ERR, 32'd0);
    send(CR, 1'b0, EV_NONE, 32'd0);
    // T3 bad character, then recovery
    send_str("12");          send("a", 1'b0, EV_ERR, 32'd0);
    send_str("34");          send(CR, 1'b0, EV_NONE, 32'd0);
    send_str("7");           send(CR, 1'b0, EV_VALID, 32'd7);
    // T4 framing error
    send_str("56");          send("7", 1'b1, EV_ERR, 32'd7);
    send(CR, 1'b0, EV_NONE, 32'd0);
    send_str("8");           send(CR, 1'b0, EV_VALID, 32'd8);
    // T5 held strobe level, then blank lines and stray LFs
    @(negedge clk);
    rx_data = "9"; rx_data_ready = 1'b1;
    repeat (20) @(negedge clk);
    rx_data_ready = 1'b0;
    repeat (2) @(negedge clk);
    send(CR, 1'b0, EV_VALID, 32'd9);
    send(CR, 1'b0, EV_NONE, 32'd0);
    send(LF, 1'b0, EV_NONE, 32'd0);
    send(LF, 1'b0, EV_NONE, 32'd0);
    send(CR, 1'b0, EV_NONE, 32'd0);
    // T6 reset mid-line
    send_str("98");
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send_str("3");           send(CR, 1'b0, EV_VALID, 32'd3);

    repeat (5) @(negedge clk);
    done = 1'b1;
  end

  // --------------------------------------------------------------- monitor
  always @(posedge clk) begin
    rst_seen <= ~rst_n;
    if (!rst_n) armed <= 1'b1;
  end

  always @(negedge clk) begin
    ev_t e;
    if (armed) begin
      if (rst_seen) begin
        exp_number = 32'd0;
        checks++;
        if (number !== 32'd0) begin
          errors++; $display("FAIL reset_number: got %0d expected 0", number);
        end
        checks++;
        if (number_valid !== 1'b0) begin
          errors++; $display("FAIL reset_valid: got %b expected 0", number_valid);
        end
        checks++;
        if (parse_error !== 1'b0) begin
          errors++; $display("FAIL reset_perr: got %b expected 0", parse_error);
        end
        checks++;
        if (busy !== 1'b0) begin
          errors++; $display("FAIL reset_busy: got %b expected 0", busy);
        end
      end else begin
        if (number_valid === 1'b1 || parse_error === 1'b1) begin
          checks++;
          if (number_valid === 1'b1 && parse_error === 1'b1) begin
            errors++; $display("FAIL both_pulses at %0t: valid=1 perr=1 expected one", $time);
          end else if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse at %0t: valid=%b perr=%b number=%0d expected none",
                     $time, number_valid, parse_error, number);
          end else begin
            e = sb_q.pop_front();
            if (e.is_err != (parse_error === 1'b1) || e.t != $time) begin
              errors++;
              $display("FAIL pulse_kind at %0t: perr=%b expected perr=%b at %0t",
                       $time, parse_error, e.is_err, e.t);
            end else if (!e.is_err) begin
              exp_number = e.val;
              if (busy !== 1'b0) begin
                errors++; $display("FAIL busy_on_valid: got %b expected 0", busy);
              end
            end
          end
        end
        checks++;
        if (number !== exp_number) begin
          errors++;
          $display("FAIL number_hold at %0t: got %0d expected %0d", $time, number, exp_number);
        end
      end
    end

    if (done) begin
      checks++;
      if (sb_q.size() != 0) begin
        errors++;
        $display("FAIL missing_pulses: got %0d outstanding expected 0", sb_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

endmodule
`default_nettype wire
